// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronizes SerialIn, times each bit from the start-bit centre and
// emits each framed word with a one-cycle SetFlag, or a FramingError on a bad stop bit.
module uart_rx_deserializer #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 SerialIn,
  output logic [WORD_SIZE-1:0] DataOut,
  output logic                 SetFlag,
  output logic                 FramingError,
  output logic                 Busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

  stateT                state;
  stateT                stateNext;
  logic                 rxMeta;
  logic                 rxS;
  logic [CNT_W-1:0]     bitCnt;
  logic [IDX_W-1:0]     bitIdx;
  logic [WORD_SIZE-1:0] shiftReg;
  logic                 cntClear;
  logic                 sampleBit;
  logic                 wordDone;
  logic                 stopBad;

  // Line synchronizer; both flops rest at the idle level
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= SerialIn;
      rxS    <= rxMeta;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!rxS) stateNext = START;
      START:   if (bitCnt == CNT_HALF) stateNext = rxS ? IDLE : DATA;
      DATA:    if (bitCnt == CNT_LAST && bitIdx == IDX_LAST) stateNext = STOP;
      STOP:    if (bitCnt == CNT_LAST) stateNext = rxS ? IDLE : BREAK;
      BREAK:   if (rxS) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Sampling strobes: the counter restarts at every sampling point
  always_comb begin
    cntClear  = 1'b0;
    sampleBit = 1'b0;
    wordDone  = 1'b0;
    stopBad   = 1'b0;
    Busy      = 1'b0;
    case (state)
      START: begin
        Busy     = 1'b1;
        cntClear = (bitCnt == CNT_HALF);
      end
      DATA: begin
        Busy      = 1'b1;
        sampleBit = (bitCnt == CNT_LAST);
        cntClear  = sampleBit;
      end
      STOP: begin
        Busy = 1'b1;
        if (bitCnt == CNT_LAST) begin
          cntClear = 1'b1;
          wordDone = rxS;
          stopBad  = !rxS;
        end
      end
      default: cntClear = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      bitCnt       <= '0;
      bitIdx       <= '0;
      shiftReg     <= '0;
      DataOut      <= '0;
      SetFlag      <= 1'b0;
      FramingError <= 1'b0;
    end else begin
      bitCnt <= cntClear ? '0 : bitCnt + 1'b1;
      if (state != DATA)
        bitIdx <= '0;
      else if (sampleBit)
        bitIdx <= (bitIdx == IDX_LAST) ? '0 : bitIdx + 1'b1;
      if (sampleBit)
        shiftReg <= {rxS, shiftReg} >> 1;
      if (wordDone)
        DataOut <= shiftReg;
      SetFlag      <= wordDone;
      FramingError <= stopBad;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized bench: frames, glitches, framing errors and resets scored against
// an event list of expected output pulses built from frame start times.
module tb_uart_rx_deserializer;

  localparam int WS  = 8;
  localparam int CPB = 16;
  localparam int LAT = 155;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          SerialIn = 1'b1;
  logic [WS-1:0] DataOut;
  logic          SetFlag;
  logic          FramingError;
  logic          Busy;

  typedef struct { int cyc; bit err; logic [WS-1:0] data; } evT;
  typedef struct { int cyc; bit val; } busyT;

  evT            expQ[$];
  busyT          busyQ[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic [WS-1:0] lastWord = '0;

  uart_rx_deserializer #(.WORD_SIZE(WS), .CLKS_PER_BIT(CPB)) dut (
    .Clock(Clock), .ResetN(ResetN), .SerialIn(SerialIn),
    .DataOut(DataOut), .SetFlag(SetFlag), .FramingError(FramingError), .Busy(Busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Monitor: exact-cycle comparison of pulses, held word and Busy
  always @(negedge Clock) begin
    bit   expSet;
    bit   expFe;
    evT   ev;
    busyT bc;
    expSet = 1'b0;
    expFe  = 1'b0;
    if (!ResetN) begin
      lastWord = '0;
      checkEq("BusyReset", {31'd0, Busy}, 32'd0);
    end else if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
      ev = expQ.pop_front();
      if (ev.err) expFe = 1'b1;
      else begin
        expSet   = 1'b1;
        lastWord = ev.data;
      end
    end
    checkEq("SetFlag", {31'd0, SetFlag}, {31'd0, expSet});
    checkEq("FramingError", {31'd0, FramingError}, {31'd0, expFe});
    checkEq("DataOut", {24'd0, DataOut}, {24'd0, lastWord});
    if (busyQ.size() > 0 && busyQ[0].cyc == cyc) begin
      bc = busyQ.pop_front();
      checkEq("Busy", {31'd0, Busy}, {31'd0, bc.val});
    end
  end

  // Driver sits just after a rising edge; each call holds a level for n clocks
  task automatic driveLevel(input bit v, input int n);
    SerialIn = v;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic sendFrame(input logic [WS-1:0] d, input bit stopBit);
    evT   ev;
    busyT bc;
    ev.cyc = cyc + LAT; ev.err = !stopBit; ev.data = d;
    expQ.push_back(ev);
    bc.cyc = cyc + 80; bc.val = 1'b1;
    busyQ.push_back(bc);
    if (!stopBit) begin
      bc.cyc = cyc + 158; bc.val = 1'b0;
      busyQ.push_back(bc);
    end
    driveLevel(1'b0, CPB);
    for (int i = 0; i < WS; i++) driveLevel(d[i], CPB);
    driveLevel(stopBit, CPB);
  endtask

  task automatic sendGlitch(input int k);
    busyT bc;
    bc.cyc = cyc + 5;  bc.val = 1'b1; busyQ.push_back(bc);
    bc.cyc = cyc + 12; bc.val = 1'b0; busyQ.push_back(bc);
    driveLevel(1'b0, k);
    driveLevel(1'b1, 12);
  endtask

  task automatic sendBadFrame(input logic [WS-1:0] d, input int holdLow, input int highGap);
    sendFrame(d, 1'b0);
    driveLevel(1'b0, holdLow);
    driveLevel(1'b1, highGap);
  endtask

  task automatic resetMidFrame(input logic [WS-1:0] d);
    driveLevel(1'b0, CPB);
    for (int i = 0; i < 3; i++) driveLevel(d[i], CPB);
    driveLevel(d[3], CPB / 2);
    ResetN = 1'b0;
    driveLevel(1'b1, 3);
    ResetN = 1'b1;
    driveLevel(1'b1, 20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge Clock);
    #1;
    ResetN = 1'b1;
    driveLevel(1'b1, 10);

    sendFrame(8'hA5, 1'b1);
    driveLevel(1'b1, 20);
    sendFrame(8'h3C, 1'b1);
    sendFrame(8'hC3, 1'b1);
    driveLevel(1'b1, 10);
    sendBadFrame(8'h5A, 40, 10);
    sendGlitch(4);
    sendFrame(8'hFF, 1'b1);
    driveLevel(1'b1, 10);
    resetMidFrame(8'h81);
    sendFrame(8'h00, 1'b1);
    driveLevel(1'b1, 5);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) sendGlitch($urandom_range(1, 6));
      else if (r == 1) sendBadFrame(WS'($urandom), $urandom_range(0, 40), $urandom_range(3, 20));
      else if (r == 2) resetMidFrame(WS'($urandom));
      else begin
        sendFrame(WS'($urandom), 1'b1);
        if ($urandom_range(0, 3) != 0) driveLevel(1'b1, $urandom_range(1, 30));
      end
    end

    driveLevel(1'b1, 200);
    checkEq("pendingPulses", expQ.size(), 32'd0);
    checkEq("pendingBusy", busyQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, Clock cycles per serial bit; legal values are even and >= 4.
REQ-003 SHALL have port Clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port ResetN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port SerialIn, input, 1, asynchronous UART line; idle high; 8N1-style frame of 1 start bit (0), WORD_SIZE data bits LSB first, then 1 stop bit (1).
REQ-006 SHALL have port DataOut, output, WORD_SIZE, last correctly framed word; drives the DataIn port of the downstream receiver buffer.
REQ-007 SHALL have port SetFlag, output, 1, one-cycle pulse when DataOut is updated; drives the downstream SetFlag port.
REQ-008 SHALL have port FramingError, output, 1, one-cycle pulse when the stop bit is sampled as 0.
REQ-009 SHALL have port Busy, output, 1, high while state is START, DATA or STOP.

Function
REQ-010 SHALL pass SerialIn through a two-flop synchronizer; all logic uses only the second-stage output (RxS).
REQ-011 SHALL implement states IDLE, START, DATA, STOP and BREAK, with one bit-timing counter (0..CLKS_PER_BIT-1) and one bit index (0..WORD_SIZE-1).
REQ-012 IDLE: on the first edge where RxS=0, SHALL go to START with counter cleared.
REQ-013 START: counter counts up to CLKS_PER_BIT/2-1, then RxS is sampled; 0 -> DATA with counter and index cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: each time the counter reaches CLKS_PER_BIT-1, RxS SHALL be sampled and shifted into the shift register MSB, with the register shifting right; the counter clears and the index increments; after the WORD_SIZE-th sample -> STOP.
REQ-015 STOP: at counter CLKS_PER_BIT-1, RxS SHALL be sampled; 1 -> DataOut loaded from the shift register, SetFlag=1 for exactly the next cycle, go to IDLE; 0 -> FramingError=1 for exactly the next cycle, DataOut unchanged, SetFlag stays 0, go to BREAK.
REQ-016 BREAK: SHALL remain until RxS=1, then go to IDLE; no start detection while in BREAK.
REQ-017 Latency: for defaults, SetFlag SHALL rise on the 152nd rising edge after the edge that leaves IDLE, which is 154 edges after the first edge that registers SerialIn low in the first synchronizer flop.
REQ-018 Back-to-back frames: a start bit beginning directly after a stop bit SHALL be detected from IDLE with no lost frame.
REQ-019 SetFlag and FramingError SHALL never be asserted in the same cycle; neither SHALL be asserted for more than one consecutive cycle.
REQ-020 DataOut SHALL change only on the edge that asserts SetFlag.
REQ-021 SerialIn transitions between sampling points SHALL have no effect other than the start detection in IDLE.

Reset
REQ-022 ResetN low SHALL immediately force state IDLE, counter 0, index 0, shift register 0, DataOut 0, SetFlag 0, FramingError 0, Busy 0, and both synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no SetFlag or FramingError pulse; after release, reception resumes from IDLE.

Verification
REQ-024 Defaults; send frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1 at 16 clks/bit) -> single SetFlag pulse 154 edges after the start bit, DataOut=0xA5, FramingError never high.
REQ-025 Send 0x3C then 0xC3 back-to-back, no idle gap -> two SetFlag pulses 160 clocks apart, DataOut 0x3C then 0xC3.
REQ-026 After 0xA5, send frame 0x5A with stop bit 0, then hold line low 40 clocks -> FramingError pulse, no SetFlag, DataOut stays 0xA5, Busy=0 in BREAK, no new start until the line returns high.
REQ-027 Drive line low for 4 clocks, then high -> START then return to IDLE, Busy high briefly, no SetFlag or FramingError; next 0xFF frame is received correctly.
REQ-028 Assert ResetN low during data bit 3 of frame 0x81, release with line high -> all outputs at reset values, no pulse; next 0x00 frame gives SetFlag with DataOut=0x00.
